// File: rtl/seg7_scan_decoder.sv
// Passive readback of a multiplexed 4-digit 7-segment display bus.
// Synchronizes the anode/segment lines, waits for each digit's pattern to
// hold steady, decodes the glyph back to a nibble and reports a 16-bit frame
// once all four digits have been seen.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   input  logic        clear,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic [3:0]  frame_err
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   typedef enum logic {SETTLE, HOLD} state_t;

   // Maps a normalised {g..a} pattern to {legal, nibble}; illegal codes give 0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] g);
      logic [4:0] r;
      case (g)
         7'h3F: r = 5'h10;
         7'h06: r = 5'h11;
         7'h5B: r = 5'h12;
         7'h4F: r = 5'h13;
         7'h66: r = 5'h14;
         7'h6D: r = 5'h15;
         7'h7D: r = 5'h16;
         7'h07: r = 5'h17;
         7'h7F: r = 5'h18;
         7'h6F: r = 5'h19;
         7'h77: r = 5'h1A;
         7'h7C: r = 5'h1B;
         7'h39: r = 5'h1C;
         7'h5E: r = 5'h1D;
         7'h79: r = 5'h1E;
         7'h71: r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [3:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
   logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
   logic [7:0]       cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [3:0][3:0]  dig_q, dig_d;
   logic [3:0]       seen_q, seen_d, err_q, err_d;
   logic [15:0]      value_q, value_d;
   logic             fv_q, fv_d;
   logic [3:0]       ferr_q, ferr_d;

   logic [3:0]       an_n;
   logic [6:0]       seg_n;
   logic             same;
   logic             onehot;
   logic [1:0]       dsel;
   logic             capture;
   logic [4:0]       glyph;
   logic [3:0]       seen_new, err_new;

   // Next-state logic: sync chain, stability counter, capture FSM, frame assembly.
   always_comb begin
      an_s1_d   = an;
      an_s2_d   = an_s1_q;
      seg_s1_d  = seg;
      seg_s2_d  = seg_s1_q;

      // Normalise after sync so that selected=1 and lit=1 from here on.
      an_n      = AN_ACTIVE_LOW  ? ~an_s2_q  : an_s2_q;
      seg_n     = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
      an_prev_d  = an_n;
      seg_prev_d = seg_n;

      same  = (an_n == an_prev_q) && (seg_n == seg_prev_q);
      cnt_d = !same ? 8'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1);

      onehot = 1'b0;
      dsel   = 2'd0;
      case (an_prev_q)
         4'b0001: begin onehot = 1'b1; dsel = 2'd0; end
         4'b0010: begin onehot = 1'b1; dsel = 2'd1; end
         4'b0100: begin onehot = 1'b1; dsel = 2'd2; end
         4'b1000: begin onehot = 1'b1; dsel = 2'd3; end
         default: ;
      endcase

      // The prev register holds the pattern the counter has been qualifying.
      glyph   = decode_glyph(seg_prev_q);
      capture = (state_q == SETTLE) && (cnt_q == CNT_MAX) && onehot && !clear;

      // A change always re-arms; clear parks in HOLD so the shown pattern
      // is not taken again until the bus moves.
      if (clear)        state_d = HOLD;
      else if (!same)   state_d = SETTLE;
      else if (capture) state_d = HOLD;
      else              state_d = state_q;

      dig_d    = dig_q;
      seen_d   = seen_q;
      err_d    = err_q;
      value_d  = value_q;
      ferr_d   = ferr_q;
      fv_d     = 1'b0;
      seen_new = seen_q;
      err_new  = err_q;

      if (clear) begin
         dig_d  = '0;
         seen_d = '0;
         err_d  = '0;
      end else if (capture) begin
         dig_d[dsel]   = glyph[3:0];
         seen_new[dsel] = 1'b1;
         err_new[dsel]  = ~glyph[4];
         if (seen_new == 4'hF) begin
            value_d = dig_d;
            ferr_d  = err_new;
            fv_d    = 1'b1;
            seen_d  = '0;
            err_d   = '0;
         end else begin
            seen_d = seen_new;
            err_d  = err_new;
         end
      end
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_s1_q    <= '0;
         an_s2_q    <= '0;
         an_prev_q  <= '0;
         seg_s1_q   <= '0;
         seg_s2_q   <= '0;
         seg_prev_q <= '0;
         cnt_q      <= '0;
         state_q    <= SETTLE;
         dig_q      <= '0;
         seen_q     <= '0;
         err_q      <= '0;
         value_q    <= '0;
         fv_q       <= 1'b0;
         ferr_q     <= '0;
      end else begin
         an_s1_q    <= an_s1_d;
         an_s2_q    <= an_s2_d;
         an_prev_q  <= an_prev_d;
         seg_s1_q   <= seg_s1_d;
         seg_s2_q   <= seg_s2_d;
         seg_prev_q <= seg_prev_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         dig_q      <= dig_d;
         seen_q     <= seen_d;
         err_q      <= err_d;
         value_q    <= value_d;
         fv_q       <= fv_d;
         ferr_q     <= ferr_d;
      end
   end

   assign value       = value_q;
   assign frame_valid = fv_q;
   assign frame_err   = ferr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans with literal expectations plus
// random bus activity, all checked each cycle against a run-length model.
module tb_seg7_scan_decoder;
   localparam int S = 4;
   localparam int N = 32768;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic        clear = 1'b0;
   logic [15:0] value;
   logic        frame_valid;
   logic [3:0]  frame_err;

   seg7_scan_decoder #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .clear(clear),
      .value(value), .frame_valid(frame_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Model: history of bus samples per edge, start index of the run each
   // sample belongs to, and whether that run has already been consumed.
   logic [10:0] hx [N];
   int          rs [N];
   bit          done [N];
   int          idx;
   logic [3:0]  m_dig [4];
   logic [3:0]  m_seen, m_err, m_ferr;
   logic [15:0] m_value;
   logic        m_fv;
   int          edge_no = 0, fv_cnt = 0, last_fv_edge = 0;

   task automatic model_reset();
      idx = 3;
      for (int i = 0; i < 3; i++) begin hx[i] = '0; rs[i] = 0; done[i] = 1'b0; end
      for (int i = 0; i < 4; i++) m_dig[i] = '0;
      m_seen = '0; m_err = '0; m_ferr = '0; m_value = '0; m_fv = 1'b0;
   endtask

   function automatic logic [4:0] lookup(input logic [6:0] g);
      for (int v = 0; v < 16; v++) if (glyph[v] == g) return {1'b1, 4'(v)};
      return 5'h00;
   endfunction

   // A pattern is taken 3 edges after it has been sampled S times in a row,
   // once per unbroken run; clear consumes the run sampled 2 edges earlier.
   task automatic model_step();
      int j, d;
      logic [3:0] sel;
      logic [4:0] g;
      hx[idx] = {an, seg};
      if (hx[idx] == hx[idx-1]) rs[idx] = rs[idx-1];
      else begin rs[idx] = idx; done[idx] = 1'b0; end
      m_fv = 1'b0;
      j = idx - 3;
      if (clear) begin
         for (int i = 0; i < 4; i++) m_dig[i] = '0;
         m_seen = '0; m_err = '0;
         done[rs[idx-2]] = 1'b1;
      end else if (!done[rs[j]] && (j - rs[j] + 1) >= S) begin
         sel = ~hx[j][10:7];
         if ($countones(sel) == 1) begin
            done[rs[j]] = 1'b1;
            d = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) d = i;
            g = lookup(~hx[j][6:0]);
            m_dig[d] = g[3:0];
            m_seen[d] = 1'b1;
            m_err[d] = ~g[4];
            if (m_seen == 4'hF) begin
               m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
               m_ferr = m_err; m_fv = 1'b1; m_seen = '0; m_err = '0;
            end
         end
      end
      idx++;
      if (idx >= N) begin
         $display("FAIL model_overflow: idx %0d required below %0d", idx, N);
         $fatal(1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      edge_no++;
      #1;
      checks++;
      if ({value, frame_valid, frame_err} !== {m_value, m_fv, m_ferr}) begin
         errors++;
         $display("FAIL cycle_compare @%0d: value=%h fv=%b err=%b, expected value=%h fv=%b err=%b",
                  edge_no, value, frame_valid, frame_err, m_value, m_fv, m_ferr);
      end
      if (frame_valid) begin fv_cnt++; last_fv_edge = edge_no; end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an = a; seg = s;
      repeat (n) tick();
   endtask

   task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input int n);
      hold(4'b1110, s0, n); hold(4'b1101, s1, n); hold(4'b1011, s2, n); hold(4'b0111, s3, n);
   endtask

   initial begin
      int f0, t_apply;
      logic [3:0] ra;
      logic [6:0] rsg;
      int dwell;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      chk("reset_value", 32'(value), 32'h0);
      chk("reset_fv_err", {27'd0, frame_valid, frame_err}, 32'h0);

      // Digit 0 alone never completes a frame.
      f0 = fv_cnt;
      hold(4'b1110, 7'h40, 10);
      chk("digit0_only_no_frame", 32'(fv_cnt - f0), 32'd0);

      // Scan 1,2,3,F; check latency from the last digit's application.
      f0 = fv_cnt;
      hold(4'b1110, ~7'h06, 8); hold(4'b1101, ~7'h5B, 8); hold(4'b1011, ~7'h4F, 8);
      t_apply = edge_no + 1;
      hold(4'b0111, ~7'h71, 8);
      chk("scan_f321_pulses", 32'(fv_cnt - f0), 32'd1);
      chk("scan_f321_value", 32'(value), 32'hF321);
      chk("scan_f321_err", 32'(frame_err), 32'h0);
      chk("scan_latency", 32'(last_fv_edge - t_apply), 32'(S + 2));

      // Glitching pattern changes every 3 cycles, never qualifies.
      f0 = fv_cnt;
      an = 4'b1110;
      for (int i = 0; i < 14; i++) hold(4'b1110, ~glyph[i % 16], 3);
      chk("glitch_no_frame", 32'(fv_cnt - f0), 32'd0);
      hold(4'b1110, ~glyph[5], 8);

      // Digit 2 blank (illegal), others "8".
      scan4(7'h00, 7'h00, 7'h7F, 7'h00, 8);
      chk("illegal_value", 32'(value), 32'h8088);
      chk("illegal_err", 32'(frame_err), 32'b0100);

      // Blanking and overlap.
      f0 = fv_cnt;
      hold(4'b1111, 7'h00, 20);
      hold(4'b1100, 7'h00, 20);
      chk("blank_overlap_no_frame", 32'(fv_cnt - f0), 32'd0);

      // Continuous scanning of A,b,C,d.
      f0 = fv_cnt;
      repeat (3) scan4(~7'h77, ~7'h7C, ~7'h39, ~7'h5E, 7);
      chk("abcd_pulses", 32'(fv_cnt - f0), 32'd3);
      chk("abcd_value", 32'(value), 32'hDCBA);

      // clear on the edge that would complete the frame.
      f0 = fv_cnt;
      hold(4'b1110, ~7'h6D, 8); hold(4'b1101, ~7'h7D, 8); hold(4'b1011, ~7'h07, 8);
      hold(4'b0111, ~7'h66, S + 2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (6) tick();
      chk("clear_no_frame", 32'(fv_cnt - f0), 32'd0);
      chk("clear_keeps_value", 32'(value), 32'hDCBA);

      // Async reset mid-frame, then a full scan.
      hold(4'b1110, ~7'h7F, 8); hold(4'b1101, ~7'h6F, 8);
      rst_n = 1'b0;
      #2;
      chk("midreset_value", 32'(value), 32'h0);
      chk("midreset_fv_err", {27'd0, frame_valid, frame_err}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      scan4(~7'h6F, ~7'h7F, ~7'h07, ~7'h7D, 8);
      chk("post_reset_value", 32'(value), 32'h6789);
      chk("post_reset_err", 32'(frame_err), 32'h0);

      // Random bus activity with occasional clear.
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 9) < 8) ra = ~(4'b0001 << $urandom_range(0, 3));
         else ra = 4'($urandom);
         if ($urandom_range(0, 9) < 7) rsg = ~glyph[$urandom_range(0, 15)];
         else rsg = 7'($urandom);
         dwell = $urandom_range(1, 10);
         an = ra; seg = rsg;
         for (int c = 0; c < dwell; c++) begin
            clear = ($urandom_range(0, 39) == 0);
            tick();
            clear = 1'b0;
         end
      end
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
